adc_fft_framer: RTL and testbench
=================================

# adc_fft_framer

Builds FFT input frames from the two ADC channels and drives them into the FFT core's streaming sink port. It is the feed side of the interface whose output side is already consumed by the magnitude and RAM-writing logic. The block runs on the FFT clock domain. On a start pulse from the debounced key, it:

- sums the two 10-bit ADC samples,
- removes the DC offset,
- decimates by a parameter,
- streams exactly one FRAME_LEN-sample frame with sop/eop framing and a valid/ready handshake.

## Interface
Parameters:
- FRAME_LEN, 256: samples per frame; a power of two, at least 2.
- DECIM, 1: capture one sample every DECIM clocks; at least 1.

Ports:
- clk  in  1  FFT-domain clock; every sample and handshake is taken on its rising edge.
- rst_n  in  1  Reset, asynchronous assert, active-low.
- start  in  1  One-cycle pulse that arms one frame. Ignored while busy.
- ad_data_1  in  10  ADC channel 1 sample, offset binary.
- ad_data_2  in  10  ADC channel 2 sample, offset binary.
- ad_otr_1  in  1  ADC channel 1 over-range flag.
- ad_otr_2  in  1  ADC channel 2 over-range flag.
- sink_ready  in  1  FFT core can accept a beat.
- sink_valid  out  1  Beat is valid.
- sink_sop  out  1  First beat of the frame; qualified by sink_valid.
- sink_eop  out  1  Last beat of the frame; qualified by sink_valid.
- sink_real  out  16  Signed sample.
- sink_imag  out  16  Always 0.
- busy  out  1  A frame is in progress.
- frame_done  out  1  One-cycle pulse after the eop beat is accepted.
- overrun  out  1  Sticky: a capture tick was lost to backpressure in the current or last frame.
- clip  out  1  Sticky: an over-range flag was seen at a capture tick in the current or last frame.

## Operation
States:
- IDLE: on start, go to STREAM. On entry to STREAM, clear decim_cnt, cap_cnt, overrun and clip.
- STREAM: go back to IDLE on acceptance of the eop beat.

decim_cnt:
- Counts 0 to DECIM-1 in STREAM, then wraps.
- A capture tick occurs when decim_cnt == 0 and cap_cnt < FRAME_LEN.

Arithmetic at each capture tick:
- sum = ad_data_1 + ad_data_2, unsigned, 11 bits (0..2046).
- sample = sum − 1024, 12-bit signed (−1024..+1022).
- sink_real = sample sign-extended to 16 bits.

Holding register (single entry):
- A tick loads it when it is empty, or when its beat is accepted in the same cycle (sink_valid && sink_ready).
- On load: sink_valid=1, sink_sop=(cap_cnt==0), sink_eop=(cap_cnt==FRAME_LEN−1), then cap_cnt increments.
- A tick while sink_valid && !sink_ready drops the sample and sets overrun. cap_cnt does not advance, so the frame still carries exactly FRAME_LEN beats.
- While sink_valid && !sink_ready, sink_real, sop and eop hold stable.
- On an accepted beat with no simultaneous load, sink_valid clears.

Flags and completion:
- clip is set if ad_otr_1 | ad_otr_2 is high in any tick cycle, dropped ticks included.
- On eop acceptance: state returns to IDLE, sink_valid clears, frame_done pulses for one cycle, and busy falls in that same cycle.
- overrun and clip hold their values until the next start.
- start in STREAM has no effect.

## Timing
- Reset value of every output is 0; state is IDLE.
- Asserting rst_n mid-frame aborts the frame immediately: sink_valid drops and there is no eop.
- With start high in cycle T:
  - busy = 1 from T+1.
  - The first tick is in cycle T+1.
  - sink_valid = 1 from T+2, with sop.
- Later ticks occur at T+1+k·DECIM.
- Latency from tick to beat presented is 1 clock.
- With DECIM=1 and sink_ready held high, the beats are contiguous: T+2 .. T+1+FRAME_LEN. eop is at T+1+FRAME_LEN and frame_done at T+2+FRAME_LEN.
- A start in the same cycle as frame_done is accepted, because the state is already IDLE.

## Test plan
- DECIM=1, sink_ready=1, ad_data_1=ad_data_2=512, start -> 256 contiguous beats with sink_real=0x0000. sop only on beat 0, eop only on beat 255, frame_done one cycle after eop, overrun=0.
- Data extremes: 1023+1023 -> 0x03FE; 0+0 -> 0xFC00; 300+700 -> 0xFFE8 (−24). sink_imag is 0 throughout.
- DECIM=4: drop sink_ready for 6 cycles while beat 10 is presented -> sink_real and sop/eop hold stable, exactly one tick is dropped, overrun=1, and the frame still totals 256 beats ending with eop.
- ad_otr_2 high for one cycle coinciding with a tick at beat 50 -> clip=1 until the next start, which clears it. An otr pulse between ticks (DECIM=4) -> clip stays 0.
- rst_n low during beat 100 -> all outputs 0 asynchronously. A following start produces a full 256-beat frame beginning with sop.
- start pulsed at beat 20 of a running frame -> ignored, and the frame ends normally at beat 255. start in the frame_done cycle -> a new frame starts, with sink_valid at +2 cycles.

Source files
------------

// File: rtl/adc_fft_framer.sv
// adc_fft_framer
//   Builds one FFT input frame per start pulse from the two ADC channels.
//   Each capture tick sums the two offset-binary samples, removes the DC
//   offset (1024) and presents the signed result to the FFT sink port through
//   a single-entry holding register with a valid/ready handshake.
//
// Ports
//   clk, rst_n            FFT-domain clock, async active-low reset
//   start                 one-cycle pulse arming a frame (ignored while busy)
//   ad_data_1/2, ad_otr_1/2  ADC samples (10-bit offset binary) and over-range
//   sink_ready            FFT core accepts a beat
//   sink_valid/sop/eop    beat framing toward the FFT core
//   sink_real/imag        signed sample / constant zero
//   busy, frame_done      frame in progress / pulse after eop accepted
//   overrun, clip         sticky per-frame flags, cleared by the next start
module adc_fft_framer #(
    parameter int FRAME_LEN = 256,
    parameter int DECIM     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [9:0]  ad_data_1,
    input  logic [9:0]  ad_data_2,
    input  logic        ad_otr_1,
    input  logic        ad_otr_2,
    input  logic        sink_ready,
    output logic        sink_valid,
    output logic        sink_sop,
    output logic        sink_eop,
    output logic [15:0] sink_real,
    output logic [15:0] sink_imag,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun,
    output logic        clip
);

    // cap counter needs one extra bit so it can hold FRAME_LEN itself
    localparam int CAP_W = $clog2(FRAME_LEN) + 1;
    localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [CAP_W-1:0] CAP_END  = CAP_W'(FRAME_LEN);
    localparam logic [CAP_W-1:0] CAP_LAST = CAP_W'(FRAME_LEN - 1);
    localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIM - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t             state_q;
    logic [DEC_W-1:0]   decim_q;
    logic [CAP_W-1:0]   cap_q;
    logic               valid_q;
    logic               sop_q;
    logic               eop_q;
    logic [15:0]        real_q;
    logic               done_q;
    logic               ovr_q;
    logic               clip_q;

    logic [DEC_W-1:0]   decim_d;
    logic [10:0]        sum;
    logic [11:0]        samp;
    logic [15:0]        real_d;
    logic               tick;
    logic               accept;
    logic               load;
    logic               drop;

    assign decim_d = (decim_q == DEC_LAST) ? '0 : decim_q + DEC_W'(1);

    assign sum    = {1'b0, ad_data_1} + {1'b0, ad_data_2};
    assign samp   = {1'b0, sum} - 12'd1024;
    assign real_d = {{4{samp[11]}}, samp};

    assign tick   = (state_q == STREAM) && (decim_q == '0) && (cap_q < CAP_END);
    assign accept = valid_q && sink_ready;
    // the holding register takes a new sample only if it is free this cycle
    assign load   = tick && (!valid_q || sink_ready);
    // a stalled beat forces the tick's sample to be discarded
    assign drop   = tick && valid_q && !sink_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            decim_q <= '0;
            cap_q   <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            real_q  <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            clip_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= STREAM;
                        decim_q <= '0;
                        cap_q   <= '0;
                        ovr_q   <= 1'b0;
                        clip_q  <= 1'b0;
                    end
                end
                STREAM: begin
                    decim_q <= decim_d;
                    if (tick && (ad_otr_1 || ad_otr_2)) clip_q <= 1'b1;
                    if (drop) ovr_q <= 1'b1;
                    if (load) begin
                        valid_q <= 1'b1;
                        real_q  <= real_d;
                        sop_q   <= (cap_q == '0);
                        eop_q   <= (cap_q == CAP_LAST);
                        cap_q   <= cap_q + CAP_W'(1);
                    end else if (accept) begin
                        valid_q <= 1'b0;
                        sop_q   <= 1'b0;
                        eop_q   <= 1'b0;
                    end
                    // no tick can follow the eop load, so this never races a load
                    if (accept && eop_q) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        sop_q   <= 1'b0;
                        eop_q   <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sink_valid = valid_q;
    assign sink_sop   = sop_q;
    assign sink_eop   = eop_q;
    assign sink_real  = real_q;
    assign sink_imag  = '0;
    assign busy       = (state_q == STREAM);
    assign frame_done = done_q;
    assign overrun    = ovr_q;
    assign clip       = clip_q;

endmodule

// File: tb/tb_adc_fft_framer.sv
module tb_adc_fft_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       start1 = 1'b0, start4 = 1'b0;
    logic       ready1 = 1'b1, ready4 = 1'b1;
    logic       otr1 = 1'b0, otr2 = 1'b0;
    logic [9:0] d1 = '0, d2 = '0;

    logic        v1, sop1, eop1, busy1, done1, ovr1, clip1;
    logic [15:0] re1, im1;
    logic        v4, sop4, eop4, busy4, done4, ovr4, clip4;
    logic [15:0] re4, im4;

    adc_fft_framer #(.FRAME_LEN(256), .DECIM(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .ad_data_1(d1), .ad_data_2(d2), .ad_otr_1(otr1), .ad_otr_2(otr2),
        .sink_ready(ready1), .sink_valid(v1), .sink_sop(sop1), .sink_eop(eop1),
        .sink_real(re1), .sink_imag(im1), .busy(busy1), .frame_done(done1),
        .overrun(ovr1), .clip(clip1)
    );

    adc_fft_framer #(.FRAME_LEN(256), .DECIM(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .ad_data_1(d1), .ad_data_2(d2), .ad_otr_1(otr1), .ad_otr_2(otr2),
        .sink_ready(ready4), .sink_valid(v4), .sink_sop(sop4), .sink_eop(eop4),
        .sink_real(re4), .sink_imag(im4), .busy(busy4), .frame_done(done4),
        .overrun(ovr4), .clip(clip4)
    );

    typedef struct packed {
        logic [15:0] re;
        logic        sop;
        logic        eop;
    } beat_t;

    beat_t q1[$];
    beat_t q4[$];
    int    pass_cnt = 0;
    int    total_cnt = 0;
    int    n4 = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input bit d4, input logic [15:0] re);
        beat_t b;
        for (int i = 0; i < 256; i++) begin
            b.re  = re;
            b.sop = (i == 0);
            b.eop = (i == 255);
            if (d4) q4.push_back(b);
            else    q1.push_back(b);
        end
    endtask

    task automatic wait_done(input bit d4, input string nm);
        bit hit = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (d4 ? done4 : done1) begin
                hit = 1'b1;
                break;
            end
        end
        check({nm, "_done"}, hit, 1);
        check({nm, "_len"}, d4 ? q4.size() : q1.size(), 0);
        check({nm, "_busy"}, d4 ? busy4 : busy1, 0);
    endtask

    // Scoreboard monitor: every presented beat must match the queue head;
    // it is popped only once accepted, so stalled beats are checked each cycle.
    always @(negedge clk) begin
        if (v1) begin
            if (q1.size() == 0) begin
                total_cnt++;
                $display("FAIL beat1_extra: got beat 0x%0h, expected none", re1);
            end else begin
                check("beat1", {re1, im1, sop1, eop1}, {q1[0].re, 16'h0000, q1[0].sop, q1[0].eop});
                if (ready1) void'(q1.pop_front());
            end
        end
        if (v4) begin
            if (q4.size() == 0) begin
                total_cnt++;
                $display("FAIL beat4_extra: got beat 0x%0h, expected none", re4);
            end else begin
                check("beat4", {re4, im4, sop4, eop4}, {q4[0].re, 16'h0000, q4[0].sop, q4[0].eop});
                if (ready4) begin
                    void'(q4.pop_front());
                    n4++;
                end
            end
        end
    end

    initial begin
        bit found;
        #3;
        check("rst_out1", {v1, sop1, eop1, re1, im1, busy1, done1, ovr1, clip1}, 0);
        check("rst_out4", {v4, sop4, eop4, re4, im4, busy4, done4, ovr4, clip4}, 0);
        #9 rst_n = 1'b1;
        repeat (2) step();

        // A: 512+512 -> 0, contiguous beats, exact timing
        d1 = 10'd512; d2 = 10'd512;
        push_frame(0, 16'h0000);
        start1 = 1'b1; step(); start1 = 1'b0;            // T+1
        check("A_busy_T1", {busy1, v1}, 2'b10);
        step();                                          // T+2
        check("A_sop_T2", {v1, sop1}, 2'b11);
        repeat (255) step();                             // T+257
        check("A_eop", {v1, eop1, done1}, 3'b110);
        step();                                          // T+258
        check("A_done", {done1, busy1, v1, ovr1}, 4'b1000);
        check("A_len", q1.size(), 0);

        // B: start in the frame_done cycle, 1023+1023 -> 0x03FE
        d1 = 10'd1023; d2 = 10'd1023;
        push_frame(0, 16'h03FE);
        start1 = 1'b1; step(); start1 = 1'b0;
        check("B_T1", {busy1, v1, done1}, 3'b100);
        step();
        check("B_sop_T2", {v1, sop1}, 2'b11);
        wait_done(0, "B");

        // C: 0+0 -> 0xFC00, ignored start at beat 20, otr on tick of beat 50
        d1 = 10'd0; d2 = 10'd0;
        push_frame(0, 16'hFC00);
        start1 = 1'b1; step(); start1 = 1'b0;            // T+1
        repeat (21) step();                              // T+22
        start1 = 1'b1; step(); start1 = 1'b0;            // T+23
        check("C_start_ignored", {busy1, done1, clip1}, 3'b100);
        repeat (28) step();                              // T+51
        otr2 = 1'b1; step(); otr2 = 1'b0;
        wait_done(0, "C");
        check("C_flags", {clip1, ovr1}, 2'b10);
        repeat (3) step();
        check("C_clip_sticky", clip1, 1);

        // D: 300+700 -> 0xFFE8, reset during beat 100, then a full frame
        d1 = 10'd300; d2 = 10'd700;
        push_frame(0, 16'hFFE8);
        start1 = 1'b1; step(); start1 = 1'b0;            // T+1
        check("D_clip_clr", clip1, 0);
        repeat (101) step();                             // T+102
        check("D_b100_valid", v1, 1);
        rst_n = 1'b0;
        #1;
        check("D_rst_out", {v1, sop1, eop1, re1, im1, busy1, done1, ovr1, clip1}, 0);
        q1.delete();
        step();
        rst_n = 1'b1;
        step();
        push_frame(0, 16'hFFE8);
        start1 = 1'b1; step(); start1 = 1'b0;
        step();
        check("D2_sop", {v1, sop1}, 2'b11);
        wait_done(0, "D2");
        check("D2_flags", {clip1, ovr1}, 2'b00);

        // E: DECIM=4, otr between ticks, 6-cycle stall on beat 10
        push_frame(1, 16'hFFE8);
        start4 = 1'b1; step(); start4 = 1'b0;            // T+1
        check("E_T1", {busy4, v4}, 2'b10);
        step();                                          // T+2
        check("E_sop_T2", {v4, sop4}, 2'b11);
        step();                                          // T+3, not a tick
        check("E_T3", v4, 0);
        otr1 = 1'b1; step(); otr1 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (v4 && n4 == 10) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("E_find_b10", found, 1);
        ready4 = 1'b0;
        repeat (6) step();
        check("E_stall", {v4, ovr4}, 2'b11);
        ready4 = 1'b1;
        wait_done(1, "E");
        check("E_flags", {ovr4, clip4}, 2'b10);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
